// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit:
// M-extension opcodes, FSM state encoding and op decode helper.
package muldiv_pkg;

  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_DIVU   = 5'h15;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_m_op(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned multiply/divide datapath on a 2*XLEN
// accumulator: shift-add for multiply, restoring trial-subtract for divide.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              div_mode,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}
    sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: acc = {partial remainder, dividend bits shifting into quotient}
    rem_sh = acc_i[2*XLEN-1:XLEN-1];
    diff   = rem_sh - {1'b0, opnd_i};
    if (div_mode) begin
      if (diff[XLEN]) acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      else            acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit in EX. Stalls the pipeline via busy
// while iterating on operand magnitudes; signs are fixed up on the last step.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            kill,
  input  logic            req,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic                div_q, div_d;
  logic                hi_q, hi_d;
  logic                neg_q, neg_d;

  logic                start;
  logic                op_div;
  logic                a_sgn, b_sgn;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                div_by_zero, div_ovf;
  logic [XLEN-1:0]     special_res;
  logic [2*XLEN-1:0]   acc_step;
  logic [2*XLEN-1:0]   full_fix;
  logic [XLEN-1:0]     pick, res_fin;

  assign start  = req && is_m_op(alu_op) && !kill;
  assign op_div = alu_op[2];

  // Operand decode for the IDLE capture
  always_comb begin
    a_sgn = a[XLEN-1] && (alu_op == OP_MULH || alu_op == OP_MULHSU ||
                          alu_op == OP_DIV  || alu_op == OP_REM);
    b_sgn = b[XLEN-1] && (alu_op == OP_MULH || alu_op == OP_DIV || alu_op == OP_REM);
    a_mag = a_sgn ? -a : a;
    b_mag = b_sgn ? -b : b;
    div_by_zero = op_div && (b == '0);
    div_ovf     = (alu_op == OP_DIV || alu_op == OP_REM) && (a == INT_MIN) && (b == '1);
    if (div_by_zero) special_res = alu_op[1] ? a : '1;
    else             special_res = alu_op[1] ? '0 : INT_MIN;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div_mode (div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_step)
  );

  // Product sign must be applied to the full width before picking a half
  always_comb begin
    full_fix = (neg_q && !div_q) ? -acc_step : acc_step;
    pick     = hi_q ? full_fix[2*XLEN-1:XLEN] : full_fix[XLEN-1:0];
    res_fin  = (neg_q && div_q) ? -pick : pick;
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    acc_d          = acc_q;
    opnd_d         = opnd_q;
    div_d          = div_q;
    hi_d           = hi_q;
    neg_d          = neg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d  = '0;
          div_d  = op_div;
          hi_d   = op_div ? alu_op[1] : (alu_op[1:0] != 2'b00);
          neg_d  = (op_div && alu_op[1]) ? a_sgn : (a_sgn ^ b_sgn);
          acc_d  = op_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
          opnd_d = op_div ? b_mag : a_mag;
          if (div_by_zero || div_ovf) begin
            result_d       = special_res;
            result_valid_d = 1'b1;
            state_d        = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (kill || !req) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
            result_d       = res_fin;
            result_valid_d = 1'b1;
            state_d        = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    opnd_q <= opnd_d;
    div_q  <= div_d;
    hi_q   <= hi_d;
    neg_q  <= neg_d;
  end

  assign busy         = !reset && start && (state_q != DONE);
  assign result_valid = result_valid_q && !kill;
  assign result       = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: randomized and directed RV32M ops checked every cycle
// against a plain-arithmetic reference model and a latency/handshake model.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        kill = 1'b0;
  logic        req = 1'b0;
  logic [4:0]  alu_op = 5'h0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        chk_en = 1'b0;
  logic        exp_busy = 1'b0;
  logic        exp_valid = 1'b0;
  logic [31:0] model_result = '0;

  ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .kill         (kill),
    .req          (req),
    .alu_op       (alu_op),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: actual %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: RV32M results straight from 64-bit integer arithmetic
  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] x,
                                             input logic [31:0] y);
    longint          sx, sy, ux, uy, p;
    longint unsigned pu;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    p  = 0;
    case (op)
      OP_MUL:    begin p = sx * sy; return p[31:0]; end
      OP_MULH:   begin p = sx * sy; return p[63:32]; end
      OP_MULHSU: begin p = sx * uy; return p[63:32]; end
      OP_MULHU:  begin pu = longint'(ux) * longint'(uy); return pu[63:32]; end
      OP_DIV: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
        p = sx / sy; return p[31:0];
      end
      OP_REM: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
        p = sx % sy; return p[31:0];
      end
      OP_DIVU: begin
        if (y == 0) return 32'hFFFFFFFF;
        p = ux / uy; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        p = ux % uy; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [4:0] op, input logic [31:0] x,
                                    input logic [31:0] y);
    if (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU} && y == 0) return 1'b1;
    if (op inside {OP_DIV, OP_REM} && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'b0, busy}, {31'b0, exp_busy});
      check("result_valid", {31'b0, result_valid}, {31'b0, exp_valid});
      check("result", result, model_result);
    end
  end

  // Cycle 0 is the IDLE capture; busy for lat cycles, result_valid in cycle lat.
  // kill_cyc >= 0 pulses kill in that cycle and abandons the op.
  task automatic do_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                       input int kill_cyc);
    int          lat;
    logic [31:0] r;
    r   = ref_result(op, x, y);
    lat = is_special(op, x, y) ? 1 : 33;
    req = 1'b1; alu_op = op; a = x; b = y; kill = 1'b0;
    for (int c = 0; c <= lat; c++) begin
      if (c == kill_cyc) begin
        kill = 1'b1; exp_busy = 1'b0; exp_valid = 1'b0;
        @(posedge clk); #1;
        kill = 1'b0; req = 1'b0;
        return;
      end
      exp_busy  = (c < lat);
      exp_valid = (c == lat);
      if (c == lat) model_result = r;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n, input logic req_v, input logic [4:0] op);
    req = req_v; alu_op = op; kill = 1'b0;
    exp_busy = 1'b0; exp_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] x, y;
    int          mode, kc, lat;

    // Busy stays low under reset even with an M op presented
    req = 1'b1; alu_op = OP_MUL; a = 32'd1; b = 32'd1;
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_valid", {31'b0, result_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;

    check("pin_mul", ref_result(OP_MUL, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    check("pin_mulhu", ref_result(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
    check("pin_mulh", ref_result(OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'h0);
    check("pin_div", ref_result(OP_DIV, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
    check("pin_rem", ref_result(OP_REM, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
    check("pin_mulhsu", ref_result(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);

    do_op(OP_MUL, 32'd7, 32'hFFFFFFFD, -1);
    check("lit_mul", result, 32'hFFFFFFEB);
    idle(1, 1'b0, 5'h0);
    do_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
    check("lit_mulhu", result, 32'hFFFFFFFE);
    do_op(OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
    check("lit_mulh", result, 32'h0);
    do_op(OP_DIV, 32'hFFFFFFF9, 32'd2, -1);
    check("lit_div", result, 32'hFFFFFFFD);
    do_op(OP_REM, 32'hFFFFFFF9, 32'd2, -1);
    check("lit_rem", result, 32'hFFFFFFFF);
    do_op(OP_DIVU, 32'd100, 32'd7, -1);
    check("lit_divu", result, 32'd14);
    do_op(OP_REMU, 32'd100, 32'd7, -1);
    check("lit_remu", result, 32'd2);

    do_op(OP_DIV, 32'd5, 32'd0, -1);
    check("lit_div0", result, 32'hFFFFFFFF);
    do_op(OP_REMU, 32'd5, 32'd0, -1);
    check("lit_remu0", result, 32'd5);
    do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1);
    check("lit_divovf", result, 32'h80000000);
    do_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, -1);
    check("lit_removf", result, 32'h0);

    // Non-M op with req high must not stall or start anything
    idle(3, 1'b1, 5'h03);

    do_op(OP_DIV, 32'd1000, 32'd7, 11);
    idle(2, 1'b0, 5'h0);
    do_op(OP_MUL, 32'd3, 32'd4, -1);
    check("lit_mul_after_kill", result, 32'd12);
    idle(1, 1'b0, 5'h0);

    do_op(OP_DIVU, 32'd9, 32'd3, -1);
    check("lit_b2b_divu", result, 32'd3);
    do_op(OP_MUL, 32'd5, 32'd6, -1);
    check("lit_b2b_mul", result, 32'd30);
    idle(1, 1'b0, 5'h0);

    for (int i = 0; i < 60; i++) begin
      op   = 5'h10 + 5'($urandom_range(0, 7));
      mode = $urandom_range(0, 9);
      x    = $urandom;
      y    = $urandom;
      if (mode == 0) y = 32'h0;
      else if (mode == 1) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
      else if (mode == 2) begin
        x = $urandom_range(0, 40) - 32'd20;
        y = $urandom_range(0, 40) - 32'd20;
      end
      lat = is_special(op, x, y) ? 1 : 33;
      kc  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, lat - 1) : -1;
      do_op(op, x, y, kc);
      case ($urandom_range(0, 2))
        0:       ;
        1:       idle(1, 1'b0, 5'h0);
        default: idle(1, 1'b1, 5'($urandom_range(0, 15)));
      endcase
    end

    // Asynchronous reset in the middle of an iteration
    do_op(OP_MULHU, 32'hFFFFFFFF, 32'h12345678, -1);
    req = 1'b1; alu_op = OP_MUL; a = 32'd11; b = 32'd13;
    exp_busy = 1'b1; exp_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    #2;
    reset = 1'b1;
    model_result = '0;
    exp_busy = 1'b0;
    #1;
    check("async_reset_busy", {31'b0, busy}, 32'd0);
    check("async_reset_result", result, 32'd0);
    check("async_reset_valid", {31'b0, result_valid}, 32'd0);
    @(posedge clk); #1;
    req = 1'b0;
    reset = 1'b0;
    idle(2, 1'b0, 5'h0);
    do_op(OP_MULHSU, 32'hFFFFFFF0, 32'h80000001, -1);
    idle(2, 1'b0, 5'h0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
